gate_unit_arbiter: RTL and testbench

Arbiter and sequencer that shares one instance of the team's combinational two-input logic-gate unit between two requesters. The gate unit has inputs A, B and outputs D=AND, O=OR, NT=NOT A, ND=NAND, NR=NOR, XR=XOR and XN=XNOR. Each requester submits an operand pair and a gate opcode over a valid/ready handshake. The block arbitrates between them, drives the gate unit's inputs, waits a programmable settle time, samples the selected gate output and returns it on a registered response channel tagged with the requester ID.

---
 rtl/gate_unit_arbiter.sv | 179 +++++++++++++++++
 tb/tb_gate_unit_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: shares one combinational two-input gate unit between two
// requesters. Arbitrates, drives the gate unit's operands for HOLD_CYCLES cycles,
// samples the selected gate output and returns it on a registered response channel.
// Optional macro GATE_ARB_FIXED_PRIO_EN: fixed priority (req0 wins ties) instead of
// round-robin.
module gate_unit_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_a,
    input  logic       req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_a,
    input  logic       req1_b,
    input  logic [2:0] req1_op,
    output logic       gu_a,
    output logic       gu_b,
    input  logic       gu_d,
    input  logic       gu_o,
    input  logic       gu_nt,
    input  logic       gu_nd,
    input  logic       gu_nr,
    input  logic       gu_xr,
    input  logic       gu_xn,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_data,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic       busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrive = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;

    // Counter reload: the accept edge itself starts the first hold cycle.
    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic       id_q, id_d;
    logic       last_grant_q, last_grant_d;
    logic       gu_a_q, gu_a_d;
    logic       gu_b_q, gu_b_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_data_q, rsp_data_d;
    logic       rsp_id_q, rsp_id_d;
    logic       rsp_err_q, rsp_err_d;

    logic grant;
    logic accept;
    logic gate_sel;

    // Grant selection: a lone requester wins; a tie goes by priority policy.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else if (req0_valid && req1_valid) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end
    end

    assign req0_ready = (state_q == StIdle) && req0_valid && (grant == 1'b0);
    assign req1_ready = (state_q == StIdle) && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    // Pick the gate output addressed by the latched opcode; illegal op reads 0.
    always_comb begin
        gate_sel = 1'b0;
        case (op_q)
            3'd0:    gate_sel = gu_d;
            3'd1:    gate_sel = gu_o;
            3'd2:    gate_sel = gu_nt;
            3'd3:    gate_sel = gu_nd;
            3'd4:    gate_sel = gu_nr;
            3'd5:    gate_sel = gu_xr;
            3'd6:    gate_sel = gu_xn;
            default: gate_sel = 1'b0;
        endcase
    end

    // Next-state logic for the IDLE -> DRIVE -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        gu_a_d       = gu_a_q;
        gu_b_d       = gu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d         = grant ? req1_op : req0_op;
                    gu_a_d       = grant ? req1_a : req0_a;
                    gu_b_d       = grant ? req1_b : req0_b;
                    id_d         = grant;
                    last_grant_d = grant;
                    cnt_d        = HoldLoad;
                    state_d      = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == 8'd0) begin
                    rsp_data_d  = (op_q == 3'd7) ? 1'b0 : gate_sel;
                    rsp_err_d   = (op_q == 3'd7);
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            op_q         <= 3'd0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            gu_a_q       <= 1'b0;
            gu_b_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            gu_a_q       <= gu_a_d;
            gu_b_q       <= gu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign gu_a      = gu_a_q;
    assign gu_b      = gu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: two instances (hold 1 and hold 4) share stimulus,
// each with its own behavioural gate unit. Table-driven request vectors plus
// sequences for contention, backpressure and reset during DRIVE.
module tb_gate_unit_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       r0v, r1v, r0a, r0b, r1a, r1b, rsp_ready;
    logic [2:0] r0op, r1op;

    // Hold-1 instance signals
    logic a_r0rdy, a_r1rdy, a_gua, a_gub, a_rv, a_rd, a_rid, a_rerr, a_busy;
    logic a_d, a_o, a_nt, a_nd, a_nr, a_xr, a_xn;
    // Hold-4 instance signals
    logic b_r0rdy, b_r1rdy, b_gua, b_gub, b_rv, b_rd, b_rid, b_rerr, b_busy;
    logic b_d, b_o, b_nt, b_nd, b_nr, b_xr, b_xn;

    assign a_d  = a_gua & a_gub;
    assign a_o  = a_gua | a_gub;
    assign a_nt = ~a_gua;
    assign a_nd = ~(a_gua & a_gub);
    assign a_nr = ~(a_gua | a_gub);
    assign a_xr = a_gua ^ a_gub;
    assign a_xn = ~(a_gua ^ a_gub);
    assign b_d  = b_gua & b_gub;
    assign b_o  = b_gua | b_gub;
    assign b_nt = ~b_gua;
    assign b_nd = ~(b_gua & b_gub);
    assign b_nr = ~(b_gua | b_gub);
    assign b_xr = b_gua ^ b_gub;
    assign b_xn = ~(b_gua ^ b_gub);

    gate_unit_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(a_r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(a_r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .gu_a(a_gua), .gu_b(a_gub),
        .gu_d(a_d), .gu_o(a_o), .gu_nt(a_nt), .gu_nd(a_nd), .gu_nr(a_nr), .gu_xr(a_xr),
        .gu_xn(a_xn),
        .rsp_valid(a_rv), .rsp_ready(rsp_ready), .rsp_data(a_rd), .rsp_id(a_rid),
        .rsp_err(a_rerr), .busy(a_busy)
    );

    gate_unit_arbiter #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(b_r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(b_r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .gu_a(b_gua), .gu_b(b_gub),
        .gu_d(b_d), .gu_o(b_o), .gu_nt(b_nt), .gu_nd(b_nd), .gu_nr(b_nr), .gu_xr(b_xr),
        .gu_xn(b_xn),
        .rsp_valid(b_rv), .rsp_ready(rsp_ready), .rsp_data(b_rd), .rsp_id(b_rid),
        .rsp_err(b_rerr), .busy(b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit       id;
        bit       a;
        bit       b;
        bit [2:0] op;
        bit       exp_data;
        bit       exp_err;
    } vec_t;

    vec_t     vecs[$];
    bit [3:0] tt[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction on dut1 with rsp_ready asserted once the response shows up.
    task automatic run_req(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        if (v.id) begin
            r1v = 1'b1; r1a = v.a; r1b = v.b; r1op = v.op;
        end else begin
            r0v = 1'b1; r0a = v.a; r0b = v.b; r0op = v.op;
        end
        #1;
        check($sformatf("ready vec%0d", idx), {14'd0, a_r0rdy, a_r1rdy},
              v.id ? 16'h1 : 16'h2);
        @(negedge clk);
        r0v = 1'b0;
        r1v = 1'b0;
        cyc = 0;
        while (!a_rv && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("latency vec%0d", idx), 16'(cyc), 16'd1);
        check($sformatf("rsp vec%0d", idx), {12'd0, a_rv, a_rd, a_rid, a_rerr},
              {12'd0, 1'b1, v.exp_data, v.id, v.exp_err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("idle after vec%0d", idx), {14'd0, a_rv, a_busy}, 16'h0);
    endtask

    initial begin
        int       ng;
        int       cyc;
        bit       seen;
        bit [3:0] grants;
        bit [3:0] exp_grants;

        // Truth tables indexed by {a,b}: bit3 = (1,1) ... bit0 = (0,0)
        tt[0] = 4'b1000; // AND
        tt[1] = 4'b1110; // OR
        tt[2] = 4'b0011; // NOT a
        tt[3] = 4'b0111; // NAND
        tt[4] = 4'b0001; // NOR
        tt[5] = 4'b0110; // XOR
        tt[6] = 4'b1001; // XNOR

        vecs.push_back('{id: 1'b0, a: 1'b1, b: 1'b0, op: 3'd5, exp_data: 1'b1, exp_err: 1'b0});
        for (int op = 0; op < 7; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                vecs.push_back('{id: 1'b1, a: ab[1], b: ab[0], op: 3'(op),
                                 exp_data: tt[op][ab], exp_err: 1'b0});
            end
        end
        vecs.push_back('{id: 1'b1, a: 1'b1, b: 1'b1, op: 3'd7, exp_data: 1'b0, exp_err: 1'b1});

        rst_n = 1'b0;
        r0v = 0; r1v = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0; r0op = 0; r1op = 0;
        rsp_ready = 1'b0;

        // Reset state
        #12;
        check("reset outs dut1", {7'd0, a_r0rdy, a_r1rdy, a_gua, a_gub, a_rv, a_rd, a_rid,
              a_rerr, a_busy}, 16'h0);
        check("reset outs dut4", {7'd0, b_r0rdy, b_r1rdy, b_gua, b_gub, b_rv, b_rd, b_rid,
              b_rerr, b_busy}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle no ready", {13'd0, a_r0rdy, a_r1rdy, a_busy}, 16'h0);

        // Reset during the second DRIVE cycle of the hold-4 instance
        do_reset();
        @(negedge clk);
        r0v = 1'b1; r0a = 1'b1; r0b = 1'b1; r0op = 3'd0;
        @(negedge clk);
        r0v = 1'b0;
        check("dut4 driving", {13'd0, b_gua, b_gub, b_busy}, 16'h7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("dut4 async reset", {7'd0, b_r0rdy, b_r1rdy, b_gua, b_gub, b_rv, b_rd, b_rid,
              b_rerr, b_busy}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_rv || a_rv) seen = 1'b1;
        end
        check("no rsp after reset", {15'd0, seen}, 16'h0);

        // Table-driven transactions on the hold-1 instance
        for (int i = 0; i < vecs.size(); i++) run_req(vecs[i], i);

        // Contention: both valid continuously, consumer always ready
        do_reset();
        @(negedge clk);
        r0v = 1'b1; r0a = 1'b0; r0b = 1'b1; r0op = 3'd1;
        r1v = 1'b1; r1a = 1'b1; r1b = 1'b1; r1op = 3'd0;
        rsp_ready = 1'b1;
        ng = 0;
        cyc = 0;
        grants = 4'd0;
        #1;
        while (ng < 4 && cyc < 40) begin
            if (a_r0rdy && a_r1rdy) check("both ready", 16'h3, 16'h1);
            if (a_r0rdy || a_r1rdy) begin
                grants[ng] = a_r1rdy;
                ng++;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        r0v = 1'b0;
        r1v = 1'b0;
`ifdef GATE_ARB_FIXED_PRIO_EN
        exp_grants = 4'b0000;
`else
        exp_grants = 4'b1010;
`endif
        check("grant count", 16'(ng), 16'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("grant %0d", i), {15'd0, grants[i]}, {15'd0, exp_grants[i]});
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        check("contention drained", {14'd0, a_rv, a_busy}, 16'h0);

        // Backpressure with illegal opcode; other requesters keep asking
        @(negedge clk);
        r0v = 1'b1; r0a = 1'b1; r0b = 1'b1; r0op = 3'd7;
        @(negedge clk);
        r1v = 1'b1;
        cyc = 0;
        while (!a_rv && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("backpressure %0d", i),
                  {9'd0, a_rv, a_rd, a_rid, a_rerr, a_busy, a_r0rdy, a_r1rdy},
                  {9'd0, 7'b1001100});
            @(negedge clk);
        end
        r0v = 1'b0;
        r1v = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("backpressure release", {14'd0, a_rv, a_busy}, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
